// File: rtl/d_ff_pipeline_pkg.sv
// Shared constants and sizing helper for the d_ff_pipeline register pipeline.
package d_ff_pipeline_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/d_ff_pipe_stage.sv
// One pipeline stage: valid bit plus data word (and parity bit when
// D_FF_PIPELINE_PARITY_EN is defined), cleared asynchronously by Rst_n.
module d_ff_pipe_stage
  import d_ff_pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             load,
  input  logic             leave,
  input  logic             clear,
  input  logic [WIDTH-1:0] d_in,
`ifdef D_FF_PIPELINE_PARITY_EN
  input  logic             p_in,
  output logic             p_out,
`endif
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  // Occupancy of this stage; a load wins over the word leaving in the same cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_r <= 1'b0;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
    end else if (leave) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Data only captures on a load, so empty stages never toggle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_r <= {WIDTH{1'b0}};
    end else if (load) begin
      data_r <= d_in;
    end else begin
      data_r <= data_r;
    end
  end

`ifdef D_FF_PIPELINE_PARITY_EN
  logic parity_r;

  // Parity bit travels alongside the data word.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      parity_r <= 1'b0;
    end else if (load) begin
      parity_r <= p_in;
    end else begin
      parity_r <= parity_r;
    end
  end

  assign p_out = parity_r;
`endif

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/d_ff_pipeline.sv
// WIDTH x DEPTH register pipeline with valid/ready on both sides, bubble
// collapsing, flush and occupancy count. Optional parity: D_FF_PIPELINE_PARITY_EN.
module d_ff_pipeline
  import d_ff_pipeline_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                             Clk,
  input  logic                             Rst_n,
  input  logic                             In_valid,
  output logic                             In_ready,
  input  logic [WIDTH-1:0]                 In_data,
  output logic                             Out_valid,
  input  logic                             Out_ready,
  output logic [WIDTH-1:0]                 Out_data,
  input  logic                             Flush,
  output logic [occ_width(DEPTH)-1:0]      Occupancy
`ifdef D_FF_PIPELINE_PARITY_EN
  ,
  output logic                             Parity_err
`endif
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v_s;
  logic [DEPTH-1:0] adv_s;
  logic [DEPTH-1:0] load_s;
  logic [WIDTH-1:0] d_s [DEPTH];
  logic             hole_s;
  logic             accept_s;
  logic             pop_s;
  logic [OCC_W-1:0] occ_r;

  // Walk from the tail: a word advances if any stage ahead is empty or the tail pops.
  always_comb begin
    adv_s  = {DEPTH{1'b0}};
    hole_s = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv_s[i] = v_s[i] & ~Flush & (hole_s | Out_ready);
      hole_s   = hole_s | ~v_s[i];
    end
  end

  assign In_ready = Rst_n & ~Flush & (~v_s[0] | adv_s[0]);
  assign accept_s = In_valid & In_ready;
  assign pop_s    = adv_s[DEPTH-1];

  // Stage 0 loads from the input, every other stage from the stage behind it.
  always_comb begin
    load_s    = {DEPTH{1'b0}};
    load_s[0] = accept_s;
    for (int i = 1; i < DEPTH; i++) begin
      load_s[i] = adv_s[i-1];
    end
  end

`ifdef D_FF_PIPELINE_PARITY_EN
  logic p_s [DEPTH];
  logic par_err_r;

  function automatic logic even_parity(input logic [WIDTH-1:0] x);
    return ^x;
  endfunction
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] d_in_s;
`ifdef D_FF_PIPELINE_PARITY_EN
    logic             p_in_s;
`endif
    if (g == 0) begin : g_head
      assign d_in_s = In_data;
`ifdef D_FF_PIPELINE_PARITY_EN
      assign p_in_s = even_parity(In_data);
`endif
    end else begin : g_body
      assign d_in_s = d_s[g-1];
`ifdef D_FF_PIPELINE_PARITY_EN
      assign p_in_s = p_s[g-1];
`endif
    end

    d_ff_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .load  (load_s[g]),
      .leave (adv_s[g]),
      .clear (Flush),
      .d_in  (d_in_s),
`ifdef D_FF_PIPELINE_PARITY_EN
      .p_in  (p_in_s),
      .p_out (p_s[g]),
`endif
      .valid (v_s[g]),
      .data  (d_s[g])
    );
  end

  // Running count of valid stages: +1 on accept, -1 on pop, cleared by flush.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (Flush) begin
      occ_r <= {OCC_W{1'b0}};
    end else begin
      occ_r <= occ_r + OCC_W'(accept_s) - OCC_W'(pop_s);
    end
  end

`ifdef D_FF_PIPELINE_PARITY_EN
  // One-cycle error pulse when the popped word's data disagrees with its parity.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      par_err_r <= 1'b0;
    end else begin
      par_err_r <= pop_s & (p_s[DEPTH-1] != even_parity(d_s[DEPTH-1]));
    end
  end

  assign Parity_err = par_err_r;
`endif

  assign Out_valid = v_s[DEPTH-1];
  assign Out_data  = v_s[DEPTH-1] ? d_s[DEPTH-1] : {WIDTH{1'b0}};
  assign Occupancy = occ_r;

endmodule

// File: tb/tb_d_ff_pipeline.sv
// Self-checking bench for d_ff_pipeline (WIDTH=8, DEPTH=4): directed scenarios
// plus randomized traffic against a word/position queue model.
module tb_d_ff_pipeline;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             Clk;
  logic             Rst_n;
  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] In_data;
  logic             Out_valid;
  logic             Out_ready;
  logic [WIDTH-1:0] Out_data;
  logic             Flush;
  logic [2:0]       Occupancy;
`ifdef D_FF_PIPELINE_PARITY_EN
  logic             Parity_err;
`endif

  d_ff_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .In_data   (In_data),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Out_data  (Out_data),
    .Flush     (Flush),
    .Occupancy (Occupancy)
`ifdef D_FF_PIPELINE_PARITY_EN
    ,
    .Parity_err(Parity_err)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: words in arrival order (oldest first) with their stage positions.
  logic [WIDTH-1:0] q_d[$];
  int               q_p[$];
  bit               m_accept;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_in_ready(input bit ordy, input bit fl);
    bit head_busy;
    head_busy = (q_p.size() > 0) && (q_p[q_p.size()-1] == 0);
    return !fl && (!head_busy || (q_p.size() < DEPTH) || ordy);
  endfunction

  task automatic model_step(input bit iv, input logic [WIDTH-1:0] id, input bit ordy,
                            input bit fl, input bit ir);
    int limit;
    int np;
    m_accept = 1'b0;
    if (fl) begin
      q_d.delete();
      q_p.delete();
    end else begin
      if (q_p.size() > 0 && q_p[0] == DEPTH - 1 && ordy) begin
        void'(q_d.pop_front());
        void'(q_p.pop_front());
      end
      limit = DEPTH;
      for (int k = 0; k < q_p.size(); k++) begin
        np = (q_p[k] + 1 < limit - 1) ? q_p[k] + 1 : limit - 1;
        q_p[k] = np;
        limit = np;
      end
      if (iv && ir) begin
        q_d.push_back(id);
        q_p.push_back(0);
        m_accept = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    bit               ev;
    logic [WIDTH-1:0] ed;
    ev = (q_p.size() > 0) && (q_p[0] == DEPTH - 1);
    ed = ev ? q_d[0] : 8'h00;
    chk("out_valid", 32'(Out_valid), 32'(ev));
    chk("out_data", 32'(Out_data), 32'(ed));
    chk("occupancy", 32'(Occupancy), 32'(q_d.size()));
`ifdef D_FF_PIPELINE_PARITY_EN
    chk("parity_err", 32'(Parity_err), 32'd0);
`endif
  endtask

  // Called one time unit after a rising edge: drive, check In_ready, clock, check outputs.
  task automatic cycle(input bit iv, input logic [WIDTH-1:0] id, input bit ordy, input bit fl);
    bit ir;
    In_valid  = iv;
    In_data   = id;
    Out_ready = ordy;
    Flush     = fl;
    #1;
    ir = model_in_ready(ordy, fl);
    chk("in_ready", 32'(In_ready), 32'(ir));
    @(posedge Clk);
    model_step(iv, id, ordy, fl, ir);
    #1;
    check_outputs();
  endtask

  initial begin
    int j;
    Rst_n     = 1'b0;
    In_valid  = 1'b0;
    In_data   = 8'h00;
    Out_ready = 1'b0;
    Flush     = 1'b0;
    #2;
    chk("rst_out_valid", 32'(Out_valid), 32'd0);
    chk("rst_out_data", 32'(Out_data), 32'd0);
    chk("rst_occupancy", 32'(Occupancy), 32'd0);
    In_valid = 1'b1;
    #1;
    chk("rst_in_ready", 32'(In_ready), 32'd0);
    In_valid = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;

    // Back-to-back stream with no stall.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'(i + 1), 1'b1, 1'b0);
      if (i == 3) chk("lat_first_word", 32'(Out_data), 32'h01);
      if (i == 5) chk("stream_occupancy", 32'(Occupancy), 32'd4);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure: fill, stall, then release.
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("bp_occupancy", 32'(Occupancy), 32'd4);
    chk("bp_out_data", 32'(Out_data), 32'h10);
    chk("bp_in_ready", 32'(In_ready), 32'd0);
    j = 4;
    for (int i = 0; i < 20 && j < 6; i++) begin
      cycle(1'b1, 8'(8'h10 + j), 1'b1, 1'b0);
      if (m_accept) j++;
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Bubble collapse under a stalled output.
    cycle(1'b1, 8'hA1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'hB2, 1'b0, 1'b0);
    chk("bubble_occupancy", 32'(Occupancy), 32'd2);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("bubble_head", 32'(Out_data), 32'hA1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("bubble_second", 32'(Out_data), 32'hB2);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("bubble_empty", 32'(Out_valid), 32'd0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0);
      chk("full_occupancy", 32'(Occupancy), 32'd4);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with a word on offer.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
    chk("pre_flush_occupancy", 32'(Occupancy), 32'd3);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("flush_occupancy", 32'(Occupancy), 32'd0);
    chk("flush_out_valid", 32'(Out_valid), 32'd0);
    chk("flush_out_data", 32'(Out_data), 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    In_valid = 1'b1;
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(Out_valid), 32'd0);
    chk("async_occupancy", 32'(Occupancy), 32'd0);
    chk("async_in_ready", 32'(In_ready), 32'd0);
    q_d.delete();
    q_p.delete();
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'(8'h5A + i), 1'b1, 1'b0);
      if (i == 3) chk("post_reset_first", 32'(Out_data), 32'h5A);
    end

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(99) < 70), 8'($urandom), ($urandom_range(99) < 55),
            ($urandom_range(99) < 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
